// File: rtl/multi_rate_divider_if.sv
// Control and status bundle for multi_rate_divider.
// The master side (game logic) programs the channels and watches the ticks.
// The slave side is the divider itself.
`timescale 1ns/1ps

interface multi_rate_divider_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    logic [NUM_CH-1:0]    Load;
    logic [CNT_WIDTH-1:0] PeriodIn;
    logic [NUM_CH-1:0]    OneShot;
    logic [NUM_CH-1:0]    Run;
    logic                 SyncRestart;
    logic [NUM_CH-1:0]    Tick;
    logic [NUM_CH-1:0]    Active;

    modport master (
        output Load,
        output PeriodIn,
        output OneShot,
        output Run,
        output SyncRestart,
        input  Tick,
        input  Active
    );

    modport slave (
        input  Load,
        input  PeriodIn,
        input  OneShot,
        input  Run,
        input  SyncRestart,
        output Tick,
        output Active
    );
endinterface

// File: rtl/multi_rate_divider.sv
// Multi-channel programmable rate divider.
// Each channel counts down from Period-1 and pulses Tick for one cycle when
// it reaches zero. It then reloads (periodic mode) or disarms (one-shot mode).
// Out of reset every channel ticks once per CLOCK_FREQUENCY clocks.
`timescale 1ns/1ps

module multi_rate_divider #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int NUM_CH          = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                ClockIn,
    input  logic                Reset,
    multi_rate_divider_if.slave bus_io
);

    localparam logic [CNT_WIDTH-1:0] RESET_PERIOD = CNT_WIDTH'(CLOCK_FREQUENCY);
    localparam logic [CNT_WIDTH-1:0] RESET_COUNT  = CNT_WIDTH'(CLOCK_FREQUENCY - 1);
    localparam logic [CNT_WIDTH-1:0] ONE          = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO         = '0;

    logic [CNT_WIDTH-1:0] period_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] period_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] counter_q [NUM_CH];
    logic [CNT_WIDTH-1:0] counter_d [NUM_CH];
    logic [NUM_CH-1:0]    mode_q;
    logic [NUM_CH-1:0]    mode_d;
    logic [NUM_CH-1:0]    armed_q;
    logic [NUM_CH-1:0]    armed_d;
    logic [NUM_CH-1:0]    tick_q;
    logic [NUM_CH-1:0]    tick_d;

    // Next state per channel. Load beats SyncRestart, which beats counting.
    // A zero period never produces a reload value, so the counter cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i]  = period_q[i];
            counter_d[i] = counter_q[i];
            mode_d[i]    = mode_q[i];
            armed_d[i]   = armed_q[i];
            tick_d[i]    = 1'b0;

            if (bus_io.Load[i]) begin
                period_d[i]  = bus_io.PeriodIn;
                mode_d[i]    = bus_io.OneShot[i];
                armed_d[i]   = (bus_io.PeriodIn != ZERO);
                counter_d[i] = (bus_io.PeriodIn != ZERO) ? (bus_io.PeriodIn - ONE) : ZERO;
            end else if (bus_io.SyncRestart) begin
                if (period_q[i] != ZERO) begin
                    counter_d[i] = period_q[i] - ONE;
                    armed_d[i]   = 1'b1;
                end
            end else if (armed_q[i] && bus_io.Run[i]) begin
                if (counter_q[i] != ZERO) begin
                    counter_d[i] = counter_q[i] - ONE;
                end else begin
                    tick_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        armed_d[i] = 1'b0;
                    end else if (period_q[i] != ZERO) begin
                        counter_d[i] = period_q[i] - ONE;
                    end
                end
            end
        end
    end

    // Channel state registers; reset makes every channel a 1 Hz periodic ticker.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]  <= RESET_PERIOD;
                counter_q[i] <= RESET_COUNT;
            end
            mode_q  <= '0;
            armed_q <= '1;
            tick_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]  <= period_d[i];
                counter_q[i] <= counter_d[i];
            end
            mode_q  <= mode_d;
            armed_q <= armed_d;
            tick_q  <= tick_d;
        end
    end

    assign bus_io.Tick   = tick_q;
    assign bus_io.Active = armed_q;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Testbench for multi_rate_divider with CLOCK_FREQUENCY=8, two channels, 8-bit counters.
// Each scenario task pushes the expected Tick/Active pattern for its window
// into a scoreboard queue. It then drives the window cycle by cycle and pops
// one expectation per cycle.
`timescale 1ns/1ps

module tb_multi_rate_divider;

    typedef struct {
        logic [1:0] tick;
        logic [1:0] active;
        string      tag;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   edgeNum = 0;
    int   ch1Start = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbQ[$];

    multi_rate_divider_if #(.NUM_CH(2), .CNT_WIDTH(8)) bus ();

    multi_rate_divider #(
        .CLOCK_FREQUENCY(8),
        .NUM_CH(2),
        .CNT_WIDTH(8)
    ) dut (
        .ClockIn(clk),
        .Reset(rstN),
        .bus_io(bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Counts rising edges so expected tick positions can be stated in edge numbers.
    always @(posedge clk) edgeNum <= edgeNum + 1;

    // Stops the run if the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic tick1At(int e);
        return (e > ch1Start) && (((e - ch1Start) % 8) == 0);
    endfunction

    function automatic exp_t mk(logic [1:0] t, logic [1:0] a, string tag);
        exp_t x;
        x.tick = t;
        x.active = a;
        x.tag = tag;
        return x;
    endfunction

    task automatic test_reset;
        exp_t e;
        bus.Load = 2'b00; bus.PeriodIn = 8'd0; bus.OneShot = 2'b00;
        bus.Run = 2'b00; bus.SyncRestart = 1'b0;
        #1 rstN = 1'b0;
        #1;
        total++;
        if (bus.Tick !== 2'b00 || bus.Active !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_async tick=%b active=%b required tick=00 active=11", bus.Tick, bus.Active);
        end
        repeat (2) @(negedge clk);
        total++;
        if (bus.Tick !== 2'b00 || bus.Active !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_held tick=%b active=%b required tick=00 active=11", bus.Tick, bus.Active);
        end
        rstN = 1'b1;
        bus.Run = 2'b11;
        ch1Start = edgeNum;
        for (int j = 1; j <= 17; j++)
            sbQ.push_back(mk(((j % 8) == 0) ? 2'b11 : 2'b00, 2'b11, "reset_cadence"));
        for (int j = 1; j <= 17; j++) begin
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    task automatic test_periodic;
        exp_t e;
        int k = edgeNum + 1;
        for (int j = 0; j <= 12; j++)
            sbQ.push_back(mk({tick1At(k + j), (j > 0) && ((j % 3) == 0)}, 2'b11, "periodic_p3"));
        for (int j = 0; j <= 12; j++) begin
            bus.Load = (j == 0) ? 2'b01 : 2'b00;
            bus.PeriodIn = 8'd3;
            bus.OneShot = 2'b00;
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    task automatic test_pause;
        exp_t e;
        int k = edgeNum + 1;
        for (int j = 0; j <= 14; j++)
            sbQ.push_back(mk({tick1At(k + j), (j == 7) || (j == 10) || (j == 13)}, 2'b11, "pause_run0"));
        for (int j = 0; j <= 14; j++) begin
            bus.Load = (j == 0) ? 2'b01 : 2'b00;
            bus.PeriodIn = 8'd3;
            bus.Run = {1'b1, !((j >= 2) && (j <= 5))};
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    task automatic test_oneshot;
        exp_t e;
        for (int j = 0; j <= 20; j++)
            sbQ.push_back(mk({(j == 5) || (j == 15), 1'b0},
                             {(j < 5) || ((j >= 10) && (j < 15)), 1'b1}, "oneshot_sync"));
        for (int j = 0; j <= 20; j++) begin
            bus.Load = (j == 0) ? 2'b10 : 2'b00;
            bus.PeriodIn = 8'd5;
            bus.OneShot = 2'b10;
            bus.Run = 2'b10;
            bus.SyncRestart = (j == 10);
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
        bus.OneShot = 2'b00;
        bus.SyncRestart = 1'b0;
    endtask

    task automatic test_zero_one;
        exp_t e;
        for (int j = 0; j <= 12; j++)
            sbQ.push_back(mk({1'b0, j >= 7}, {1'b0, j >= 6}, "period_zero_one"));
        for (int j = 0; j <= 12; j++) begin
            bus.Load = ((j == 0) || (j == 6)) ? 2'b01 : 2'b00;
            bus.PeriodIn = (j < 6) ? 8'd0 : 8'd1;
            bus.Run = 2'b11;
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    task automatic test_load_on_expiry;
        exp_t e;
        for (int j = 0; j <= 13; j++)
            sbQ.push_back(mk({1'b0, (j == 8) || (j == 12)}, 2'b01, "load_on_expiry"));
        for (int j = 0; j <= 13; j++) begin
            bus.Load = ((j == 0) || (j == 4)) ? 2'b01 : 2'b00;
            bus.PeriodIn = 8'd4;
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bus.Load = 2'b01; bus.PeriodIn = 8'd1;
        @(posedge clk); @(negedge clk);
        bus.Load = 2'b00;
        @(posedge clk); @(negedge clk);
        total++;
        if (bus.Tick !== 2'b01 || bus.Active !== 2'b01) begin
            bad++;
            $display("[TB] FAIL pre_reset tick=%b active=%b required tick=01 active=01", bus.Tick, bus.Active);
        end
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        total++;
        if (bus.Tick !== 2'b00 || bus.Active !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_mid tick=%b active=%b required tick=00 active=11", bus.Tick, bus.Active);
        end
        @(negedge clk);
        rstN = 1'b1;
        ch1Start = edgeNum;
        for (int j = 1; j <= 17; j++)
            sbQ.push_back(mk(((j % 8) == 0) ? 2'b11 : 2'b00, 2'b11, "reset_mid_cadence"));
        for (int j = 1; j <= 17; j++) begin
            @(posedge clk); @(negedge clk);
            e = sbQ.pop_front();
            total++;
            if (bus.Tick !== e.tick || bus.Active !== e.active) begin
                bad++;
                $display("[TB] FAIL %s j=%0d tick=%b active=%b required tick=%b active=%b", e.tag, j, bus.Tick, bus.Active, e.tick, e.active);
            end
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        test_reset();
        test_periodic();
        test_pause();
        test_oneshot();
        test_zero_one();
        test_load_on_expiry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
